// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: start address,
// buffer depth, FSM state encoding and the {PC, instruction} buffer entry.
package fetch_pkg;

  localparam int DATA_W          = 32;
  localparam int FETCH_BUF_DEPTH = 2;
  localparam int CNT_W           = $clog2(FETCH_BUF_DEPTH + 1);

  localparam logic [DATA_W-1:0] INS_START_ADDRESS = 32'h0000_1000;

  typedef logic [CNT_W-1:0] count_t;
  localparam count_t BUF_FULL = count_t'(FETCH_BUF_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_SQUASH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [DATA_W-1:0] next_pc(input logic [DATA_W-1:0] pc);
    return pc + DATA_W'(4);
  endfunction

endpackage

// File: rtl/ins_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and the datapath.
// master = fetch unit view, slave = memory/datapath/branch-unit view.
interface ins_fetch_unit_if;
  import fetch_pkg::*;

  logic              IMEM_req;
  logic [DATA_W-1:0] IMEM_addr;
  logic              IMEM_ack;
  logic [DATA_W-1:0] IMEM_data;
  logic              FETCH_valid;
  logic [DATA_W-1:0] FETCH_instruction;
  logic [DATA_W-1:0] FETCH_PC;
  logic              FETCH_ready;
  logic              redirect_valid;
  logic [DATA_W-1:0] redirect_PC;
  logic              FETCH_misaligned;

  modport master (
    output IMEM_req, IMEM_addr, FETCH_valid, FETCH_instruction, FETCH_PC,
           FETCH_misaligned,
    input  IMEM_ack, IMEM_data, FETCH_ready, redirect_valid, redirect_PC
  );

  modport slave (
    input  IMEM_req, IMEM_addr, FETCH_valid, FETCH_instruction, FETCH_PC,
           FETCH_misaligned,
    output IMEM_ack, IMEM_data, FETCH_ready, redirect_valid, redirect_PC
  );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry {PC, instruction} FIFO with registered head, flush and
// simultaneous push/pop support.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t entry_i,
  output count_t       count_o,
  output logic         valid_o,
  output fetch_entry_t head_o
);

  fetch_entry_t head_q, tail_q;
  count_t       count_q;
  logic         do_push, do_pop;

  assign do_push = push_i && (count_q != BUF_FULL);
  assign do_pop  = pop_i && (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      count_q <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b11: begin
          // Only reachable with one entry held: the new word becomes head.
          head_q <= entry_i;
        end
        2'b10: begin
          if (count_q == '0) head_q <= entry_i;
          else               tail_q <= entry_i;
          count_q <= count_q + count_t'(1);
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - count_t'(1);
        end
        default: ;
      endcase
    end
  end

  assign count_o = count_q;
  assign valid_o = (count_q != '0);
  assign head_o  = head_q;

endmodule

// File: rtl/ins_fetch_unit.sv
// Instruction fetch unit: request FSM (IDLE/BUSY/SQUASH) feeding a 2-entry buffer.
// Optional macro INS_ALIGN_CHECK_EN enables the sticky misaligned-redirect fault.
module ins_fetch_unit
  import fetch_pkg::*;
(
  input  logic             SYS_clk,
  input  logic             SYS_reset,
  ins_fetch_unit_if.master bus
);

  fetch_state_e      state_q;
  logic [DATA_W-1:0] fetch_pc_q, addr_q;
  logic [DATA_W-1:0] redir_pc, pc_eff;
  logic              req_q, misaligned_q;
  logic              redir_bad, fault_nxt;
  logic              push, pop, flush, head_valid;
  count_t            count, count_nxt;
  fetch_entry_t      head, push_entry;

`ifdef INS_ALIGN_CHECK_EN
  assign redir_pc  = bus.redirect_PC;
  assign redir_bad = bus.redirect_valid && (bus.redirect_PC[1:0] != 2'b00);
  assign bus.FETCH_misaligned = misaligned_q;
`else
  logic unused_redir_lsb;
  assign unused_redir_lsb = ^{bus.redirect_PC[1:0], misaligned_q};
  assign redir_pc  = {bus.redirect_PC[DATA_W-1:2], 2'b00};
  assign redir_bad = 1'b0;
  assign bus.FETCH_misaligned = 1'b0;
`endif

  // A redirect flushes the buffer and overrides any same-cycle pop or push.
  assign flush      = bus.redirect_valid;
  assign pop        = head_valid && bus.FETCH_ready && !bus.redirect_valid;
  assign push       = (state_q == ST_BUSY) && bus.IMEM_ack && !bus.redirect_valid;
  assign push_entry = '{pc: addr_q, instr: bus.IMEM_data};
  assign fault_nxt  = misaligned_q || redir_bad;
  assign pc_eff     = bus.redirect_valid ? redir_pc : fetch_pc_q;

  always_comb begin
    count_nxt = count;
    if (flush)              count_nxt = '0;
    else if (push && !pop)  count_nxt = count + count_t'(1);
    else if (pop && !push)  count_nxt = count - count_t'(1);
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= INS_START_ADDRESS;
      addr_q       <= INS_START_ADDRESS;
      req_q        <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= fault_nxt;
      unique case (state_q)
        ST_IDLE: begin
          fetch_pc_q <= pc_eff;
          if (!fault_nxt && (count_nxt < BUF_FULL)) begin
            state_q <= ST_BUSY;
            addr_q  <= pc_eff;
            req_q   <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (bus.redirect_valid) begin
            fetch_pc_q <= redir_pc;
            if (bus.IMEM_ack) begin
              state_q <= ST_IDLE;
              req_q   <= 1'b0;
            end else begin
              state_q <= ST_SQUASH;
            end
          end else if (bus.IMEM_ack) begin
            fetch_pc_q <= next_pc(fetch_pc_q);
            addr_q     <= next_pc(fetch_pc_q);
            if (count_nxt >= BUF_FULL) begin
              state_q <= ST_IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        ST_SQUASH: begin
          if (bus.redirect_valid) fetch_pc_q <= redir_pc;
          if (bus.IMEM_ack) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  fetch_buffer u_buf (
    .clk_i   (SYS_clk),
    .rst_i   (SYS_reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .entry_i (push_entry),
    .count_o (count),
    .valid_o (head_valid),
    .head_o  (head)
  );

  assign bus.IMEM_req          = req_q;
  assign bus.IMEM_addr         = addr_q;
  assign bus.FETCH_valid       = head_valid;
  assign bus.FETCH_instruction = head.instr;
  assign bus.FETCH_PC          = head.pc;

endmodule

// File: doc/ins_fetch_unit.md
INS_FETCH_UNIT -- requirements
Module: ins_fetch_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: SYS_clk input 1, rising-edge clock for all state.
REQ-002 SHALL have SYS_reset input 1, synchronous active-high reset.
REQ-003 SHALL have IMEM_req output 1, instruction-read request held until acknowledged.
REQ-004 SHALL have IMEM_addr output 32, word address of the pending request, stable while IMEM_req=1 and no ack.
REQ-005 SHALL have IMEM_ack input 1, one-cycle pulse marking IMEM_data valid for the pending request; may arrive in the same cycle IMEM_req first rises.
REQ-006 SHALL have IMEM_data input 32, returned instruction word.
REQ-007 SHALL have FETCH_valid output 1, head buffer entry presented to DATA_PATH.
REQ-008 SHALL have FETCH_instruction output 32, head entry instruction.
REQ-009 SHALL have FETCH_PC output 32, head entry address.
REQ-010 SHALL have FETCH_ready input 1, consumer accepts head when FETCH_valid=1 and FETCH_ready=1.
REQ-011 SHALL have redirect_valid input 1, one-cycle pulse for a taken jump/branch.
REQ-012 SHALL have redirect_PC input 32, new fetch target, sampled when redirect_valid=1.
REQ-013 SHALL have FETCH_misaligned output 1, sticky misaligned-target fault (see Configuration).

Function
REQ-014 SHALL hold a 2-entry FIFO of {PC, instruction}; FETCH_valid = count>0; outputs driven from registered head.
REQ-015 SHALL implement states IDLE (no outstanding request), BUSY (request live, result kept), SQUASH (request live, result discarded); IMEM_req=1 only in BUSY and SQUASH.
REQ-016 IDLE->BUSY when count<2 and no fault; IMEM_addr = fetch_pc.
REQ-017 BUSY with IMEM_ack: push {fetch_pc, IMEM_data}; fetch_pc += 4 (wraps modulo 2^32); stay BUSY if post-update count<2, else IDLE.
REQ-018 Pop occurs on FETCH_valid & FETCH_ready; push and pop in the same cycle SHALL leave count unchanged, data order preserved.
REQ-019 No request SHALL be issued while count=2; a push SHALL never occur into a full buffer.
REQ-020 redirect_valid SHALL flush the buffer (count=0, FETCH_valid=0 next cycle), ignore any same-cycle pop, and load fetch_pc=redirect_PC.
REQ-021 Redirect in BUSY without ack -> SQUASH; IMEM_addr SHALL remain the old address until its ack.
REQ-022 Redirect in BUSY with same-cycle ack -> data dropped, state IDLE.
REQ-023 SQUASH with ack -> data dropped, state IDLE; redirect in SQUASH updates fetch_pc only.
REQ-024 Latency: first instruction from redirect/reset SHALL be FETCH_valid the cycle after its ack; zero-wait memory sustains one instruction per cycle.

Reset
REQ-025 On SYS_reset: state=IDLE, fetch_pc=INS_START_ADDRESS, count=0, IMEM_req=0, IMEM_addr=INS_START_ADDRESS, FETCH_valid=0, FETCH_instruction=0, FETCH_PC=0, FETCH_misaligned=0.
REQ-026 Reset mid-request SHALL abandon the request; a late ack after reset while IDLE SHALL be ignored.
REQ-027 IMEM_req SHALL rise in the first cycle after SYS_reset deasserts.

Configuration
REQ-028 Macro INS_ALIGN_CHECK_EN defined: redirect_PC[1:0]!=0 SHALL set FETCH_misaligned (sticky until reset), flush the buffer, and block further requests (in-flight request completes as SQUASH).
REQ-029 Macro undefined: redirect_PC[1:0] SHALL be forced to 00 and FETCH_misaligned tied 0.

Structure
REQ-030 Shared package fetch_pkg SHALL hold INS_START_ADDRESS, FETCH_BUF_DEPTH=2, the state encoding, and the {PC, instruction} entry type.
REQ-031 FIFO SHALL be sub-module fetch_buffer (push, pop, flush, count, head outputs).

Verification
REQ-032 Reset, zero-wait memory (ack same cycle as req), FETCH_ready=1 -> FETCH_PC sequence INS_START_ADDRESS, +4, +8 on consecutive cycles.
REQ-033 FETCH_ready=0, fixed 3-cycle ack latency -> exactly 2 entries buffered, IMEM_req stays 0 afterward; raise FETCH_ready -> FIFO order preserved, fetching resumes.
REQ-034 Redirect to 0x0000_0100 while BUSY, ack 2 cycles later with 0xDEADBEEF -> word dropped, next IMEM_addr=0x100, first FETCH_PC=0x100.
REQ-035 Redirect to 0x200 coincident with ack and pop -> data dropped, buffer empty next cycle, next request at 0x200.
REQ-036 fetch_pc=0xFFFF_FFFC, ack -> next IMEM_addr=0x0000_0000.
REQ-037 With INS_ALIGN_CHECK_EN, redirect to 0x102 -> FETCH_misaligned=1, FETCH_valid=0, IMEM_req=0 until reset; without it, next IMEM_addr=0x100.
